src_control_unit: RTL

- Hardwired Moore-style sequencer for the single-bus SRC datapath (PC, MA/MD, register file, A/C ALU registers, IR, CON logic).
- Generates one control-step word per clock: fetch (T0-T2), then opcode-specific execute steps (T3-T7).
- Handles the memory Read/Write/Done handshake with a timeout.
- Guarantees at most one bus driver per cycle.

---
 rtl/src_ctrl_pkg.sv | 52 +++++
 rtl/src_mem_wait.sv | 29 ++
 rtl/src_control_unit.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/src_ctrl_pkg.sv
// Shared types for the SRC hardwired control unit: step encoding, opcodes,
// ALU function codes and the per-step control word.
package src_ctrl_pkg;

   typedef enum logic [3:0] {
      S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
   } step_e;

   localparam logic [4:0] OP_NOP  = 5'd0;
   localparam logic [4:0] OP_LD   = 5'd1;
   localparam logic [4:0] OP_ST   = 5'd3;
   localparam logic [4:0] OP_LA   = 5'd5;
   localparam logic [4:0] OP_BR   = 5'd8;
   localparam logic [4:0] OP_BRL  = 5'd9;
   localparam logic [4:0] OP_ADD  = 5'd12;
   localparam logic [4:0] OP_ADDI = 5'd13;
   localparam logic [4:0] OP_SUB  = 5'd14;
   localparam logic [4:0] OP_NEG  = 5'd15;
   localparam logic [4:0] OP_AND  = 5'd20;
   localparam logic [4:0] OP_ANDI = 5'd21;
   localparam logic [4:0] OP_OR   = 5'd22;
   localparam logic [4:0] OP_ORI  = 5'd23;
   localparam logic [4:0] OP_NOT  = 5'd24;
   localparam logic [4:0] OP_STOP = 5'd31;

   typedef enum logic [3:0] {
      ALU_PASS, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NEG, ALU_NOT, ALU_INC4
   } alu_op_e;

   typedef struct packed {
      logic    pc_out, pc_in, inc4, ma_in, md_out, md_in, read, write, ir_in;
      logic    c1, c2, gra, grb, grc, r_out, ba_out, r_in;
      logic    a_in, c_in, c_out, con_in;
      alu_op_e alu_op;
   } ctrl_t;

   // Address arithmetic for la/ld/st always adds the displacement.
   function automatic alu_op_e alu_for(input logic [4:0] op);
      alu_op_e f;
      case (op)
         OP_ADD, OP_ADDI, OP_LA, OP_LD, OP_ST: f = ALU_ADD;
         OP_SUB:                               f = ALU_SUB;
         OP_AND, OP_ANDI:                      f = ALU_AND;
         OP_OR, OP_ORI:                        f = ALU_OR;
         OP_NEG:                               f = ALU_NEG;
         OP_NOT:                               f = ALU_NOT;
         default:                              f = ALU_PASS;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/src_mem_wait.sv
// Memory handshake wait tracker: counts unanswered wait cycles and flags a
// timeout on the last permitted cycle; done on that cycle still proceeds.
module src_mem_wait #(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic active,
   input  logic done,
   output logic proceed,
   output logic timeout
);
   localparam int CW = $clog2(MEM_TIMEOUT);

   logic [CW-1:0] cnt_q, cnt_d;

   assign proceed = active & done;
   assign timeout = active & ~done & (cnt_q == CW'(MEM_TIMEOUT - 1));

   always_comb begin
      cnt_d = '0;
      if (active && !done && !timeout) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end
endmodule

// File: rtl/src_control_unit.sv
// Hardwired Moore sequencer for the single-bus SRC datapath: step register
// plus a combinational decode of {step, opcode, con} into the control word.
module src_control_unit
   import src_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int OPC_W       = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [OPC_W-1:0] opcode,
   input  logic             con,
   input  logic             done,
   output logic             PCout, PCin, INC4,
   output logic             MAin, MDout, MDin,
   output logic             Read, Write,
   output logic             IRin, c1, c2,
   output logic             Gra, Grb, Grc, Rout, BAout, Rin,
   output logic             Ain, Cin, Cout, CONin,
   output logic [3:0]       alu_op,
   output logic             halted,
   output logic             illegal,
   output logic             bus_err
);
   step_e step_q, step_d;
   logic  first_q, bus_err_q;
   logic  wait_act, proceed, timeout;
   ctrl_t cw;

   logic is_alu3, is_imm, is_addr, is_ld, is_st, is_un, is_br, is_brl;
   logic is_nop, is_stop, is_legal;

   assign is_alu3  = opcode inside {OP_ADD, OP_SUB, OP_AND, OP_OR};
   assign is_imm   = opcode inside {OP_ADDI, OP_ANDI, OP_ORI};
   assign is_ld    = (opcode == OP_LD);
   assign is_st    = (opcode == OP_ST);
   assign is_addr  = is_ld | is_st | (opcode == OP_LA);
   assign is_un    = opcode inside {OP_NEG, OP_NOT};
   assign is_br    = (opcode == OP_BR);
   assign is_brl   = (opcode == OP_BRL);
   assign is_nop   = (opcode == OP_NOP);
   assign is_stop  = (opcode == OP_STOP);
   assign is_legal = is_alu3 | is_imm | is_addr | is_un | is_br | is_brl | is_nop | is_stop;

   src_mem_wait #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait (
      .clk     (clk),
      .rst     (rst),
      .active  (wait_act),
      .done    (done),
      .proceed (proceed),
      .timeout (timeout)
   );

   always_comb begin
      step_d = step_q;
      case (step_q)
         S_IDLE, S_HALT: if (start) step_d = S_T0;
         S_T0: step_d = S_T1;
         S_T1: begin
            if (proceed)      step_d = S_T2;
            else if (timeout) step_d = S_HALT;
         end
         S_T2: step_d = S_T3;
         S_T3: begin
            if (is_stop) step_d = S_HALT;
            else if (is_alu3 | is_imm | is_addr | is_un | is_br | is_brl) step_d = S_T4;
            else step_d = S_T0;
         end
         S_T4: step_d = (is_alu3 | is_imm | is_addr | is_brl) ? S_T5 : S_T0;
         S_T5: step_d = (is_ld | is_st) ? S_T6 : S_T0;
         S_T6: begin
            if (!(is_ld | is_st)) step_d = S_T0;
            else if (proceed)     step_d = S_T7;
            else if (timeout)     step_d = S_HALT;
         end
         S_T7: step_d = S_T0;
         default: step_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         step_q    <= S_IDLE;
         first_q   <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         step_q  <= step_d;
         // Marks the first cycle of any step so PC is loaded only once in T1.
         first_q <= (step_d != step_q);
         if (timeout) bus_err_q <= 1'b1;
         else if (start && (step_q == S_IDLE || step_q == S_HALT)) bus_err_q <= 1'b0;
      end
   end

   always_comb begin
      cw       = '0;
      wait_act = 1'b0;
      illegal  = 1'b0;
      case (step_q)
         S_T0: begin
            cw.pc_out = 1'b1; cw.ma_in = 1'b1; cw.inc4 = 1'b1; cw.c_in = 1'b1;
            cw.alu_op = ALU_INC4;
         end
         S_T1: begin
            cw.c_out = 1'b1; cw.pc_in = first_q; cw.read = 1'b1; wait_act = 1'b1;
         end
         S_T2: begin
            cw.md_out = 1'b1; cw.ir_in = 1'b1;
         end
         S_T3: begin
            if (is_alu3 | is_imm) begin cw.grb = 1'b1; cw.r_out = 1'b1; cw.a_in = 1'b1; end
            if (is_addr) begin cw.grb = 1'b1; cw.ba_out = 1'b1; cw.a_in = 1'b1; end
            if (is_un) begin
               cw.grc = 1'b1; cw.r_out = 1'b1; cw.c_in = 1'b1; cw.alu_op = alu_for(opcode);
            end
            if (is_br | is_brl) begin cw.grc = 1'b1; cw.r_out = 1'b1; cw.con_in = 1'b1; end
            illegal = ~is_legal;
         end
         S_T4: begin
            if (is_alu3) begin
               cw.grc = 1'b1; cw.r_out = 1'b1; cw.c_in = 1'b1; cw.alu_op = alu_for(opcode);
            end
            if (is_imm | is_addr) begin cw.c2 = 1'b1; cw.c_in = 1'b1; cw.alu_op = alu_for(opcode); end
            if (is_un) begin cw.c_out = 1'b1; cw.gra = 1'b1; cw.r_in = 1'b1; end
            if (is_br) begin cw.grb = 1'b1; cw.r_out = 1'b1; cw.pc_in = con; end
            if (is_brl) begin cw.pc_out = 1'b1; cw.gra = 1'b1; cw.r_in = con; end
         end
         S_T5: begin
            if (is_alu3 | is_imm | (is_addr & ~is_ld & ~is_st)) begin
               cw.c_out = 1'b1; cw.gra = 1'b1; cw.r_in = 1'b1;
            end
            if (is_ld | is_st) begin cw.c_out = 1'b1; cw.ma_in = 1'b1; end
            if (is_brl) begin cw.grb = 1'b1; cw.r_out = 1'b1; cw.pc_in = con; end
         end
         S_T6: begin
            wait_act = is_ld | is_st;
            cw.read  = is_ld;
            if (is_st) begin cw.gra = 1'b1; cw.r_out = 1'b1; cw.md_in = 1'b1; cw.write = 1'b1; end
         end
         S_T7: begin
            if (is_ld) begin cw.md_out = 1'b1; cw.gra = 1'b1; cw.r_in = 1'b1; end
         end
         default: ;
      endcase
   end

   assign PCout   = cw.pc_out;
   assign PCin    = cw.pc_in;
   assign INC4    = cw.inc4;
   assign MAin    = cw.ma_in;
   assign MDout   = cw.md_out;
   assign MDin    = cw.md_in;
   assign Read    = cw.read;
   assign Write   = cw.write;
   assign IRin    = cw.ir_in;
   assign c1      = cw.c1;
   assign c2      = cw.c2;
   assign Gra     = cw.gra;
   assign Grb     = cw.grb;
   assign Grc     = cw.grc;
   assign Rout    = cw.r_out;
   assign BAout   = cw.ba_out;
   assign Rin     = cw.r_in;
   assign Ain     = cw.a_in;
   assign Cin     = cw.c_in;
   assign Cout    = cw.c_out;
   assign CONin   = cw.con_in;
   assign alu_op  = cw.alu_op;
   assign halted  = (step_q == S_HALT);
   assign bus_err = bus_err_q;
endmodule
